// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
//   - arbiter FSM state encoding
//   - clog2: minimum counter width (never below 1 bit)
package wb_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_OWN   = 2'd1;
  localparam arb_state_t ST_ABORT = 2'd2;

  // Bits needed to hold the values 0..v-1. Always at least 1 bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Watchdog for hung slave transfers.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clr_i    : force the timer to zero (arbiter not owning an active cycle)
//   busy_i   : requests outstanding
//   kick_i   : slave responded (ack or err) this cycle
//   expire_o : combinational; TIMEOUT busy cycles passed without a response
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic busy_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int             TW   = clog2(TIMEOUT);
  localparam logic [TW-1:0]  LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmr_q, tmr_d;

  // tmr holds the number of quiet busy cycles already seen; the current
  // cycle is the TIMEOUT-th one when tmr has reached TIMEOUT-1.
  assign expire_o = ~clr_i & busy_i & ~kick_i & (tmr_q == LAST);

  always_comb begin
    tmr_d = tmr_q + 1'b1;
    if (clr_i || !busy_i || kick_i || expire_o) tmr_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master to one-slave pipelined Wishbone (B4) arbiter.
// Round-robin grant held for a whole bus cycle, outstanding-request limit,
// and a watchdog that aborts the owner with a one-cycle err on a hung slave.
//   m0_wb_* / m1_wb_* : master ports (_o = driven by master, _i = to master)
//   s_wb_*            : slave port
//   MAX_OUT           : accepted-but-unanswered request limit
//   TIMEOUT           : quiet busy cycles before abort
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // master 0
  input  logic [AW-1:0]   m0_wb_addr_o,
  input  logic [DW-1:0]   m0_wb_dat_o,
  input  logic [DW/8-1:0] m0_wb_sel_o,
  input  logic            m0_wb_cyc_o,
  input  logic            m0_wb_stb_o,
  input  logic            m0_wb_we_o,
  output logic [DW-1:0]   m0_wb_dat_i,
  output logic            m0_wb_stall_i,
  output logic            m0_wb_ack_i,
  output logic            m0_wb_err_i,
  // master 1
  input  logic [AW-1:0]   m1_wb_addr_o,
  input  logic [DW-1:0]   m1_wb_dat_o,
  input  logic [DW/8-1:0] m1_wb_sel_o,
  input  logic            m1_wb_cyc_o,
  input  logic            m1_wb_stb_o,
  input  logic            m1_wb_we_o,
  output logic [DW-1:0]   m1_wb_dat_i,
  output logic            m1_wb_stall_i,
  output logic            m1_wb_ack_i,
  output logic            m1_wb_err_i,
  // slave
  output logic [AW-1:0]   s_wb_addr_o,
  output logic [DW-1:0]   s_wb_dat_o,
  output logic [DW/8-1:0] s_wb_sel_o,
  output logic            s_wb_cyc_o,
  output logic            s_wb_stb_o,
  output logic            s_wb_we_o,
  input  logic [DW-1:0]   s_wb_dat_i,
  input  logic            s_wb_stall_i,
  input  logic            s_wb_ack_i,
  input  logic            s_wb_err_i
);

  localparam int            SW    = DW / 8;
  localparam int            OW    = clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX_V = OW'(MAX_OUT);

  // Masters packed side by side so the owner can simply index them.
  logic [1:0]         m_cyc, m_stb, m_we;
  logic [1:0][AW-1:0] m_addr;
  logic [1:0][DW-1:0] m_wdat;
  logic [1:0][SW-1:0] m_sel;
  logic [1:0]         m_stall, m_ack, m_err;
  logic [1:0][DW-1:0] m_rdat;

  assign m_cyc  = {m1_wb_cyc_o,  m0_wb_cyc_o};
  assign m_stb  = {m1_wb_stb_o,  m0_wb_stb_o};
  assign m_we   = {m1_wb_we_o,   m0_wb_we_o};
  assign m_addr = {m1_wb_addr_o, m0_wb_addr_o};
  assign m_wdat = {m1_wb_dat_o,  m0_wb_dat_o};
  assign m_sel  = {m1_wb_sel_o,  m0_wb_sel_o};

  assign {m1_wb_stall_i, m0_wb_stall_i} = m_stall;
  assign {m1_wb_ack_i,   m0_wb_ack_i}   = m_ack;
  assign {m1_wb_err_i,   m0_wb_err_i}   = m_err;
  assign m0_wb_dat_i = m_rdat[0];
  assign m1_wb_dat_i = m_rdat[1];

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q,  last_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          err_q,   err_d;

  logic own_cyc, own_stb, full, busy, resp, accept, expire, wd_clr;

  assign own_cyc = m_cyc[owner_q];
  assign own_stb = m_stb[owner_q];
  assign full    = (outst_q == MAX_V);
  assign busy    = (outst_q != '0);
  // A response with nothing outstanding is spurious and ignored everywhere.
  assign resp    = (s_wb_ack_i | s_wb_err_i) & busy;
  assign accept  = s_wb_stb_o & ~s_wb_stall_i;
  assign wd_clr  = (state_q != ST_OWN) | ~own_cyc;

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .busy_i   (busy),
    .kick_i   (resp),
    .expire_o (expire)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;    // m0 wins the first tie
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    outst_d = outst_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc) begin
          state_d = ST_OWN;
          owner_d = (&m_cyc) ? ~last_q : m_cyc[1];
          outst_d = '0;
        end
      end
      ST_OWN: begin
        if (!own_cyc) begin
          // Release wins over a simultaneous watchdog expiry.
          state_d = ST_IDLE;
          last_d  = owner_q;
          outst_d = '0;
        end else if (expire) begin
          state_d = ST_ABORT;
          outst_d = '0;
          err_d   = 1'b1;
        end else begin
          case ({accept, resp})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
          endcase
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s_wb_addr_o = m_addr[owner_q];
    s_wb_dat_o  = m_wdat[owner_q];
    s_wb_sel_o  = m_sel[owner_q];
    s_wb_we_o   = m_we[owner_q];
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    m_stall     = 2'b11;
    m_ack       = 2'b00;
    m_err       = 2'b00;
    m_rdat      = '0;
    case (state_q)
      ST_OWN: begin
        s_wb_cyc_o       = own_cyc;
        s_wb_stb_o       = own_cyc & own_stb & ~full;
        m_stall[owner_q] = s_wb_stall_i | full;
        // Gated by own_cyc so responses in the release cycle are dropped.
        m_ack[owner_q]   = s_wb_ack_i & busy & own_cyc;
        m_err[owner_q]   = s_wb_err_i & busy & own_cyc;
        m_rdat[owner_q]  = s_wb_dat_i;
      end
      ST_ABORT: m_err[owner_q] = err_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
  localparam int AW = 32, DW = 32, SW = 4, MAX_OUT = 4, TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    mcyc, mstb, mwe;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwdat [2];
  logic [SW-1:0] msel  [2];
  logic [DW-1:0] sdat;
  logic          sstall, sack, serr;

  logic [DW-1:0] m0_dat, m1_dat;
  logic          m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdat;
  logic [SW-1:0] s_sel;
  logic          s_cyc, s_stb, s_we;

  wb_rr_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_wb_addr_o(maddr[0]), .m0_wb_dat_o(mwdat[0]), .m0_wb_sel_o(msel[0]),
    .m0_wb_cyc_o(mcyc[0]), .m0_wb_stb_o(mstb[0]), .m0_wb_we_o(mwe[0]),
    .m0_wb_dat_i(m0_dat), .m0_wb_stall_i(m0_stall), .m0_wb_ack_i(m0_ack), .m0_wb_err_i(m0_err),
    .m1_wb_addr_o(maddr[1]), .m1_wb_dat_o(mwdat[1]), .m1_wb_sel_o(msel[1]),
    .m1_wb_cyc_o(mcyc[1]), .m1_wb_stb_o(mstb[1]), .m1_wb_we_o(mwe[1]),
    .m1_wb_dat_i(m1_dat), .m1_wb_stall_i(m1_stall), .m1_wb_ack_i(m1_ack), .m1_wb_err_i(m1_err),
    .s_wb_addr_o(s_addr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_dat_i(sdat), .s_wb_stall_i(sstall), .s_wb_ack_i(sack), .s_wb_err_i(serr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = nobody owns, 1 = owned, 2 = aborted.
  int mode, own, last, pend, quiet;
  bit err_pulse, mon;

  task automatic model_check();
    logic [1:0]    e_stall, e_ack, e_err;
    logic [DW-1:0] e_dat [2];
    logic          e_cyc, e_stb;
    e_stall = 2'b11; e_ack = 2'b00; e_err = 2'b00;
    e_dat[0] = '0; e_dat[1] = '0; e_cyc = 1'b0; e_stb = 1'b0;
    if (mode == 1) begin
      e_cyc        = mcyc[own];
      e_stb        = mcyc[own] && mstb[own] && pend < MAX_OUT;
      e_stall[own] = sstall || pend == MAX_OUT;
      e_ack[own]   = mcyc[own] && sack && pend > 0;
      e_err[own]   = mcyc[own] && serr && pend > 0;
      e_dat[own]   = sdat;
    end else if (mode == 2) begin
      e_err[own] = err_pulse;
    end
    chk("s_cyc", s_cyc, e_cyc);
    chk("s_stb", s_stb, e_stb);
    chk("m0_stall", m0_stall, e_stall[0]);
    chk("m1_stall", m1_stall, e_stall[1]);
    chk("m0_ack", m0_ack, e_ack[0]);
    chk("m1_ack", m1_ack, e_ack[1]);
    chk("m0_err", m0_err, e_err[0]);
    chk("m1_err", m1_err, e_err[1]);
    chk("m0_dat", m0_dat, e_dat[0]);
    chk("m1_dat", m1_dat, e_dat[1]);
    if (e_cyc) begin
      chk("s_addr", s_addr, maddr[own]);
      chk("s_wdat", s_wdat, mwdat[own]);
      chk("s_sel", s_sel, msel[own]);
      chk("s_we", s_we, mwe[own]);
    end
  endtask

  task automatic model_update();
    bit rsp, acc;
    if (rst) begin
      mode = 0; last = 1; pend = 0; quiet = 0; err_pulse = 0;
    end else begin
      case (mode)
        0: if (mcyc != 2'b00) begin
             own  = (mcyc == 2'b11) ? 1 - last : (mcyc[1] ? 1 : 0);
             mode = 1; pend = 0; quiet = 0;
           end
        1: if (!mcyc[own]) begin
             last = own; mode = 0; pend = 0; quiet = 0;
           end else begin
             rsp = (sack || serr) && pend > 0;
             acc = mstb[own] && pend < MAX_OUT && !sstall;
             if (pend > 0 && !rsp && quiet == TIMEOUT - 1) begin
               mode = 2; pend = 0; quiet = 0; err_pulse = 1;
             end else begin
               quiet = (pend > 0 && !rsp) ? quiet + 1 : 0;
               pend  = pend + int'(acc) - int'(rsp);
             end
           end
        default: begin
          err_pulse = 0;
          if (!mcyc[own]) begin last = own; mode = 0; end
        end
      endcase
    end
  endtask

  task automatic tick_chk(); @(negedge clk); if (mon) model_check(); endtask
  task automatic tick_end(); if (mon) model_update(); @(posedge clk); #1; endtask
  task automatic step(); tick_chk(); tick_end(); endtask
  task automatic drv_idle(); mcyc = 0; mstb = 0; sack = 0; serr = 0; sstall = 0; endtask
  task automatic do_reset(); drv_idle(); rst = 1; step(); rst = 0; endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit [1:0] cyc, stb; bit ack;
    bit [1:0] e_stall, e_ack; bit e_cyc, e_stb;
  } vec_t;
  vec_t tbl[$];

  task automatic add(bit r, bit [1:0] c, bit [1:0] s, bit a,
                     bit [1:0] est, bit [1:0] eak, bit ec, bit es);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.ack = a;
    v.e_stall = est; v.e_ack = eak; v.e_cyc = ec; v.e_stb = es;
    tbl.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_n, ack_n, first_ack, fifth, maxp, errs, err_at;
    int due[$];
    drv_idle();
    mwe = 2'b01; sdat = 32'hDEADBEEF;
    maddr[0] = 32'h1000_0000; maddr[1] = 32'h2000_0000;
    mwdat[0] = 32'hAAAA_0000; mwdat[1] = 32'hBBBB_1111;
    msel[0] = 4'hF; msel[1] = 4'h3;
    mon = 0;
    repeat (2) @(posedge clk);
    #1;
    mode = 0; last = 1; pend = 0; quiet = 0; err_pulse = 0; own = 0;
    mon = 1;
    rst = 0;

    // single read, then round-robin ties ({m1,m0} bit order)
    add(0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 0, 0);  // reset state
    add(0, 2'b01, 2'b01, 0, 2'b11, 2'b00, 0, 0);  // grant cycle
    add(0, 2'b01, 2'b01, 0, 2'b10, 2'b00, 1, 1);  // stb accepted
    add(0, 2'b01, 2'b00, 1, 2'b10, 2'b01, 1, 0);  // ack forwarded
    add(0, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0);  // release
    add(1, 2'b00, 2'b00, 0, 2'b11, 2'b00, 0, 0);  // reset, m0 wins next tie
    for (int r = 0; r < 4; r++) begin
      add(0, 2'b11, 2'b00, 0, 2'b11, 2'b00, 0, 0);
      add(0, 2'b11, 2'b00, 0, (r % 2 == 0) ? 2'b10 : 2'b01, 2'b00, 1, 0);
      add(0, 2'b00, 2'b00, 0, (r % 2 == 0) ? 2'b10 : 2'b01, 2'b00, 0, 0);
    end
    foreach (tbl[i]) begin
      rst = tbl[i].rst; mcyc = tbl[i].cyc; mstb = tbl[i].stb; sack = tbl[i].ack;
      tick_chk();
      chk($sformatf("tbl%0d_stall", i), {m1_stall, m0_stall}, tbl[i].e_stall);
      chk($sformatf("tbl%0d_ack", i), {m1_ack, m0_ack}, tbl[i].e_ack);
      chk($sformatf("tbl%0d_scyc", i), s_cyc, tbl[i].e_cyc);
      chk($sformatf("tbl%0d_sstb", i), s_stb, tbl[i].e_stb);
      if (tbl[i].e_ack[0]) chk($sformatf("tbl%0d_dat", i), m0_dat, 32'hDEADBEEF);
      tick_end();
    end
    rst = 0; drv_idle();

    // MAX_OUT limit: 6 pipelined requests, acks 10 cycles after acceptance
    do_reset();
    acc_n = 0; ack_n = 0; first_ack = -1; fifth = -1; maxp = 0;
    mcyc = 2'b01;
    for (int c = 0; c < 80 && ack_n < 6; c++) begin
      mstb[0] = (acc_n < 6);
      sack = (due.size() > 0 && due[0] == c);
      tick_chk();
      if (acc_n - ack_n == MAX_OUT) chk("full_stall", m0_stall, 1'b1);
      if (sack) begin void'(due.pop_front()); ack_n++; if (first_ack < 0) first_ack = c; end
      if (s_stb && !sstall) begin
        due.push_back(c + 10); acc_n++;
        if (acc_n == 5) fifth = c;
      end
      if (acc_n - ack_n > maxp) maxp = acc_n - ack_n;
      tick_end();
    end
    chk("maxout_acks", ack_n, 6);
    chk("maxout_peak", maxp, MAX_OUT);
    chk("fifth_after_ack", fifth, first_ack + 1);
    drv_idle(); step();

    // watchdog: one request, slave silent
    do_reset();
    mcyc = 2'b01; mstb = 2'b01; step();
    tick_chk(); chk("wd_accept", s_stb, 1'b1); tick_end();
    mstb = 2'b00; errs = 0; err_at = -1;
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      tick_chk();
      if (m0_err) begin errs++; err_at = k; chk("wd_scyc", s_cyc, 1'b0); end
      tick_end();
    end
    chk("wd_err_count", errs, 1);
    chk("wd_err_time", err_at, TIMEOUT + 1);
    tick_chk(); chk("abort_stall", m0_stall, 1'b1); chk("abort_scyc", s_cyc, 1'b0); tick_end();
    mcyc = 2'b00; step();
    mcyc = 2'b01; mstb = 2'b01;
    tick_chk(); chk("post_abort_idle", s_cyc, 1'b0); tick_end();
    tick_chk(); chk("post_abort_own", s_cyc, 1'b1); tick_end();
    drv_idle(); step();

    // m1 releases with two requests outstanding; late acks are dropped
    do_reset();
    mcyc = 2'b10; mstb = 2'b10; step();
    tick_chk(); chk("rel_acc1", s_stb, 1'b1); tick_end();
    tick_chk(); chk("rel_acc2", s_stb, 1'b1); tick_end();
    drv_idle(); step(); step();
    sack = 1;
    for (int k = 0; k < 2; k++) begin
      tick_chk();
      chk("late_m0_ack", m0_ack, 1'b0); chk("late_m1_ack", m1_ack, 1'b0);
      chk("late_scyc", s_cyc, 1'b0);
      tick_end();
    end
    sack = 0; mcyc = 2'b11; step();
    tick_chk(); chk("rel_next_m0", m0_stall, 1'b0); chk("rel_next_m1", m1_stall, 1'b1); tick_end();
    drv_idle(); step();

    // reset while m0 owns with three outstanding
    do_reset();
    mcyc = 2'b01; mstb = 2'b01; step(); step(); step(); step();
    mstb = 2'b00; rst = 1; step(); rst = 0;
    mcyc = 2'b11;
    tick_chk();
    chk("rst_scyc", s_cyc, 1'b0); chk("rst_m0_stall", m0_stall, 1'b1); chk("rst_m1_stall", m1_stall, 1'b1);
    tick_end();
    mstb = 2'b01;
    for (int k = 0; k < MAX_OUT; k++) begin
      tick_chk(); chk("rst_tie_m0_accept", s_stb & ~m0_stall, 1'b1); tick_end();
    end
    drv_idle(); step();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 9) == 0) mcyc[m] = ~mcyc[m];
        mstb[m] = mcyc[m] & $urandom_range(0, 1);
        maddr[m] = $urandom; mwdat[m] = $urandom; msel[m] = 4'($urandom); mwe[m] = 1'($urandom);
      end
      sstall = ($urandom_range(0, 3) == 0);
      sack = ((n / 250) % 2 == 1) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      serr = ($urandom_range(0, 31) == 0);
      sdat = $urandom;
      step();
    end
    rst = 0; drv_idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
